// File: rtl/simd_addsub_pipe_pkg.sv
// Shared types and lane-geometry helper for the pipelined SIMD add/subtract unit.
package simd_pkg;

    localparam int SEG_W = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } simd_op_e;

    typedef enum logic [1:0] {
        MODE_4    = 2'b00,
        MODE_8    = 2'b01,
        MODE_16   = 2'b10,
        MODE_FULL = 2'b11
    } simd_mode_e;

    // True when segment seg_idx is the lowest segment of its lane. Full-width
    // lanes start only at segment 0, which also covers 16-bit lanes on a 16-bit datapath.
    function automatic logic lane_bottom(input int unsigned seg_idx, input simd_mode_e mode);
        logic r_bottom;
        case (mode)
            MODE_4:    r_bottom = 1'b1;
            MODE_8:    r_bottom = (seg_idx[0] == 1'b0);
            MODE_16:   r_bottom = (seg_idx[1:0] == 2'b00);
            MODE_FULL: r_bottom = (seg_idx == 32'd0);
            default:   r_bottom = 1'b1;
        endcase
        return r_bottom;
    endfunction

endpackage

// File: rtl/simd_addsub_pipe_seg_adder.sv
// One 4-bit ripple segment; lanes are formed by chaining or breaking the carry between segments.
module simd_seg_adder
    import simd_pkg::*;
(
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b_eff,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{SEG_W{1'b0}}, cin};

endmodule

// File: rtl/simd_addsub_pipe.sv
// Two-stage SIMD add/subtract with per-lane carry flags and valid/ready backpressure.
// Optional unsigned per-lane saturation is enabled by defining SIMD_SATURATE_EN.
module simd_addsub_pipe
    import simd_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_a,
    input  logic [DATA_W-1:0]       in_b,
    input  logic                    in_op,
    input  logic [1:0]              in_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_res,
    output logic [DATA_W/SEG_W-1:0] out_carry
);

    localparam int N_SEG = DATA_W / SEG_W;

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_a;
    logic [DATA_W-1:0] r_s1_b;
    simd_op_e          r_s1_op;
    simd_mode_e        r_s1_mode;

    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_res;
    logic [N_SEG-1:0]  r_s2_carry;

    logic              w_s2_adv;
    logic              w_s1_adv;
    logic              w_sub;
    logic [DATA_W-1:0] w_b_eff;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_res;
    logic [N_SEG-1:0]  w_carry;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = w_s2_adv;
    assign in_ready = !r_s1_valid || w_s1_adv;

    assign w_sub   = (r_s1_op == OP_SUB);
    assign w_b_eff = w_sub ? ~r_s1_b : r_s1_b;

    // Each segment is its own generate scope so the carry chain is a set of scalars.
    for (genvar g = 0; g < N_SEG; g++) begin : g_seg
        logic w_bottom;
        logic w_top;
        logic w_cin;
        logic w_cout;
        logic w_lane_c;

        assign w_bottom = lane_bottom(g, r_s1_mode);

        if (g == 0) begin : g_cin0
            assign w_cin = w_sub;
        end else begin : g_cinn
            assign w_cin = w_bottom ? w_sub : g_seg[g-1].w_cout;
        end

        if (g == N_SEG - 1) begin : g_toplast
            assign w_top    = 1'b1;
            assign w_lane_c = w_cout;
        end else begin : g_topn
            assign w_top    = g_seg[g+1].w_bottom;
            assign w_lane_c = w_top ? w_cout : g_seg[g+1].w_lane_c;
        end

        simd_seg_adder u_seg (
            .a     (r_s1_a[g*SEG_W +: SEG_W]),
            .b_eff (w_b_eff[g*SEG_W +: SEG_W]),
            .cin   (w_cin),
            .sum   (w_sum[g*SEG_W +: SEG_W]),
            .cout  (w_cout)
        );

        assign w_carry[g] = w_top & w_cout;

`ifdef SIMD_SATURATE_EN
        // w_lane_c is the carry out of this segment's lane: overflow for add, no-borrow for subtract.
        assign w_res[g*SEG_W +: SEG_W] =
            (!w_sub &&  w_lane_c) ? {SEG_W{1'b1}} :
            ( w_sub && !w_lane_c) ? {SEG_W{1'b0}} :
                                    w_sum[g*SEG_W +: SEG_W];
`else
        assign w_res[g*SEG_W +: SEG_W] = w_sum[g*SEG_W +: SEG_W];
`endif
    end

    // Stage 1: capture operands whenever the stage can take a new beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= {DATA_W{1'b0}};
            r_s1_b     <= {DATA_W{1'b0}};
            r_s1_op    <= OP_ADD;
            r_s1_mode  <= MODE_4;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a    <= in_a;
                r_s1_b    <= in_b;
                r_s1_op   <= simd_op_e'(in_op);
                r_s1_mode <= simd_mode_e'(in_mode);
            end
        end
    end

    // Stage 2: register result and flags; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_res   <= {DATA_W{1'b0}};
            r_s2_carry <= {N_SEG{1'b0}};
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_res   <= w_res;
                r_s2_carry <= w_carry;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_res   = r_s2_res;
    assign out_carry = r_s2_carry;

endmodule
